// File: rtl/id_pkg.sv
// Shared decode constants for the instruction-decode stage.
package id_pkg;

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LDI = 4'h3;
    localparam logic [3:0] OP_BEQ = 4'hE;
    localparam logic [3:0] OP_JMP = 4'hF;

    // Instruction field bit positions
    localparam int unsigned OPC_MSB = 13;
    localparam int unsigned OPC_LSB = 10;
    localparam int unsigned RD_MSB  = 9;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RA_MSB  = 6;
    localparam int unsigned RA_LSB  = 4;
    localparam int unsigned RB_MSB  = 3;
    localparam int unsigned RB_LSB  = 1;
    localparam int unsigned IMM_W   = 7;

    // Every opcode except NOP and the control-flow ones writes rd.
    function automatic logic is_writer(input logic [3:0] op);
        return !(op == OP_NOP || op == OP_BEQ || op == OP_JMP);
    endfunction

endpackage

// File: rtl/etapa_id_banco_registros.sv
// 8-entry register file: one write port, two read ports with write bypass, R0 reads zero.
module banco_registros #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [2:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [2:0]        raddr_a_i,
    input  logic [2:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [8];

    // Storage update; entry 0 is never written so it stays at its reset value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && waddr_i != 3'd0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports; a same-cycle write to the read address is forwarded.
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (raddr_a_i != 3'd0) begin
            rdata_a_o = (we_i && waddr_i == raddr_a_i) ? wdata_i : mem_q[raddr_a_i];
        end
        if (raddr_b_i != 3'd0) begin
            rdata_b_o = (we_i && waddr_i == raddr_b_i) ? wdata_i : mem_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/etapa_id.sv
// Instruction-decode stage: register file, ID/EX register, branch resolution and squash.
module etapa_id
    import id_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FLUSH_SLOTS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [13:0]       instruccion,
    input  logic [3:0]        opcode,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              sel_pc,
    output logic [2:0]        sel_dir,
    output logic              valid_out,
    output logic [3:0]        op_out,
    output logic [2:0]        rd_out,
    output logic [DATA_W-1:0] a_val,
    output logic [DATA_W-1:0] b_val,
    output logic [DATA_W-1:0] imm_out,
    output logic              we_out
);

    logic [2:0]        rd_f, ra_f, rb_f;
    logic [DATA_W-1:0] ra_val, rb_val;
    logic              redirect;

    logic              sel_pc_q, sel_pc_d;
    logic [2:0]        sel_dir_q, sel_dir_d;
    logic              valid_q, valid_d;
    logic [3:0]        op_q, op_d;
    logic [2:0]        rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic              we_q, we_d;
    logic [1:0]        squash_q, squash_d;

    assign rd_f = instruccion[RD_MSB:RD_LSB];
    assign ra_f = instruccion[RA_MSB:RA_LSB];
    assign rb_f = instruccion[RB_MSB:RB_LSB];

    banco_registros #(
        .DATA_W(DATA_W)
    ) u_banco (
        .clk_i    (clk),
        .rst_i    (rst),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr_a_i(ra_f),
        .raddr_b_i(rb_f),
        .rdata_a_o(ra_val),
        .rdata_b_o(rb_val)
    );

    // BEQ compares the bypassed operands, so a same-cycle write-back is honoured.
    assign redirect = (opcode == OP_JMP) || (opcode == OP_BEQ && ra_val == rb_val);

    // Next ID/EX bundle; squashed slots drop valid/we and cannot redirect.
    always_comb begin
        squash_d  = squash_q;
        sel_pc_d  = 1'b0;
        sel_dir_d = sel_dir_q;
        valid_d   = 1'b0;
        we_d      = 1'b0;
        op_d      = opcode;
        rd_d      = rd_f;
        a_d       = ra_val;
        b_d       = rb_val;
        imm_d     = {{(DATA_W - IMM_W){1'b0}}, instruccion[IMM_W-1:0]};
        if (squash_q != 2'd0) begin
            squash_d = squash_q - 2'd1;
        end else begin
            valid_d = 1'b1;
            we_d    = is_writer(opcode);
            if (redirect) begin
                sel_pc_d  = 1'b1;
                sel_dir_d = rd_f;
                squash_d  = 2'(FLUSH_SLOTS);
            end
        end
    end

    // ID/EX register; reset forces a redirect to entry 0 plus a full squash.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_pc_q  <= 1'b1;
            sel_dir_q <= 3'd0;
            valid_q   <= 1'b0;
            op_q      <= 4'd0;
            rd_q      <= 3'd0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            we_q      <= 1'b0;
            squash_q  <= 2'(FLUSH_SLOTS);
        end else begin
            sel_pc_q  <= sel_pc_d;
            sel_dir_q <= sel_dir_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            we_q      <= we_d;
            squash_q  <= squash_d;
        end
    end

    assign sel_pc    = sel_pc_q;
    assign sel_dir   = sel_dir_q;
    assign valid_out = valid_q;
    assign op_out    = op_q;
    assign rd_out    = rd_q;
    assign a_val     = a_q;
    assign b_val     = b_q;
    assign imm_out   = imm_q;
    assign we_out    = we_q;

`ifndef SYNTHESIS
    // The separate opcode input must agree with the instruction's opcode field.
    opcode_match_a: assert property (@(posedge clk) disable iff (rst)
        opcode == instruccion[OPC_MSB:OPC_LSB]);
`endif

endmodule

// File: tb/tb_etapa_id.sv
// Directed, table-driven bench for etapa_id.
module tb_etapa_id;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] instruccion;
    logic [3:0]  opcode;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        sel_pc;
    logic [2:0]  sel_dir;
    logic        valid_out;
    logic [3:0]  op_out;
    logic [2:0]  rd_out;
    logic [15:0] a_val, b_val, imm_out;
    logic        we_out;

    int n_cmp  = 0;
    int n_fail = 0;

    etapa_id #(
        .DATA_W     (16),
        .FLUSH_SLOTS(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instruccion(instruccion),
        .opcode     (opcode),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .sel_pc     (sel_pc),
        .sel_dir    (sel_dir),
        .valid_out  (valid_out),
        .op_out     (op_out),
        .rd_out     (rd_out),
        .a_val      (a_val),
        .b_val      (b_val),
        .imm_out    (imm_out),
        .we_out     (we_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] instr;
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
        logic        e_sel_pc;
        logic [2:0]  e_sel_dir;
        logic        e_valid;
        logic [3:0]  e_op;
        logic [2:0]  e_rd;
        logic [15:0] e_a;
        logic [15:0] e_b;
        logic [15:0] e_imm;
        logic        e_we;
    } vec_t;

    function automatic logic [13:0] mk_r(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 1'b0};
    endfunction

    function automatic logic [13:0] mk_i(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [6:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic vec_t mkv(input logic [13:0] instr, input logic we, input logic [2:0] wa,
                                 input logic [15:0] wd, input logic spc, input logic [2:0] sdir,
                                 input logic vld, input logic [3:0] op, input logic [2:0] rd,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] imm, input logic wen);
        vec_t v;
        v.instr = instr; v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
        v.e_sel_pc = spc; v.e_sel_dir = sdir; v.e_valid = vld; v.e_op = op; v.e_rd = rd;
        v.e_a = a; v.e_b = b; v.e_imm = imm; v.e_we = wen;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Check outputs against a vector; payload fields only when the slot is valid or forced.
    task automatic check_out(input string tag, input vec_t v, input bit all_fields);
        chk({tag, ".sel_pc"}, 32'(sel_pc), 32'(v.e_sel_pc));
        if (v.e_sel_pc) chk({tag, ".sel_dir"}, 32'(sel_dir), 32'(v.e_sel_dir));
        chk({tag, ".valid"}, 32'(valid_out), 32'(v.e_valid));
        chk({tag, ".we"}, 32'(we_out), 32'(v.e_we));
        if (v.e_valid || all_fields) begin
            chk({tag, ".op"}, 32'(op_out), 32'(v.e_op));
            chk({tag, ".rd"}, 32'(rd_out), 32'(v.e_rd));
            chk({tag, ".a"}, 32'(a_val), 32'(v.e_a));
            chk({tag, ".b"}, 32'(b_val), 32'(v.e_b));
            chk({tag, ".imm"}, 32'(imm_out), 32'(v.e_imm));
        end
    endtask

    // Drive one slot, clock it, then check just after the edge.
    task automatic apply(input string tag, input vec_t v, input bit all_fields);
        logic [13:0] ins;
        ins         = v.instr;
        instruccion = ins;
        opcode      = ins[13:10];
        wb_en       = v.wb_en;
        wb_addr     = v.wb_addr;
        wb_data     = v.wb_data;
        @(posedge clk);
        #1;
        check_out(tag, v, all_fields);
    endtask

    localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, LDI = 4'h3, ALU5 = 4'h5;
    localparam logic [3:0] BEQ = 4'hE, JMP = 4'hF;

    vec_t vecs[17];

    initial begin
        rst = 1'b1;
        instruccion = '0;
        opcode = '0;
        wb_en = 1'b0;
        wb_addr = '0;
        wb_data = '0;

        // Reset state
        @(posedge clk);
        apply("rst", mkv(14'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        rst = 1'b0;
        apply("rel_squash", mkv(14'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        apply("rel_valid", mkv(14'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);

        // instr, wb_en, wb_addr, wb_data | sel_pc, sel_dir, valid, op, rd, a, b, imm, we
        vecs[0]  = mkv(mk_r(NOP, 0, 0, 0), 1, 2, 16'd5, 0, 0, 1, NOP, 0, 0, 0, 0, 0);
        vecs[1]  = mkv(mk_r(NOP, 0, 0, 0), 1, 3, 16'd7, 0, 0, 1, NOP, 0, 0, 0, 0, 0);
        vecs[2]  = mkv(mk_r(ADD, 1, 2, 3), 0, 0, 0, 0, 0, 1, ADD, 1, 5, 7, 16'h26, 1);
        vecs[3]  = mkv(mk_r(ADD, 5, 4, 2), 1, 4, 16'h00AA, 0, 0, 1, ADD, 5, 16'hAA, 5,
                       16'h44, 1);
        vecs[4]  = mkv(mk_r(NOP, 0, 0, 0), 1, 0, 16'h1234, 0, 0, 1, NOP, 0, 0, 0, 0, 0);
        vecs[5]  = mkv(mk_r(SUB, 6, 0, 4), 0, 0, 0, 0, 0, 1, SUB, 6, 0, 16'hAA, 16'h08, 1);
        vecs[6]  = mkv(mk_i(LDI, 7, 7'h7F), 0, 0, 0, 0, 0, 1, LDI, 7, 0, 0, 16'h7F, 1);
        vecs[7]  = mkv(mk_r(ALU5, 1, 3, 2), 0, 0, 0, 0, 0, 1, ALU5, 1, 7, 5, 16'h34, 1);
        vecs[8]  = mkv(mk_r(NOP, 0, 0, 0), 1, 2, 16'd9, 0, 0, 1, NOP, 0, 0, 0, 0, 0);
        vecs[9]  = mkv(mk_r(BEQ, 6, 2, 3), 1, 3, 16'd9, 1, 6, 1, BEQ, 6, 9, 9, 16'h26, 0);
        vecs[10] = mkv(mk_r(ADD, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mkv(mk_r(NOP, 0, 0, 0), 1, 3, 16'd4, 0, 0, 1, NOP, 0, 0, 0, 0, 0);
        vecs[12] = mkv(mk_r(NOP, 0, 0, 0), 0, 0, 0, 0, 0, 1, NOP, 0, 0, 0, 0, 0);
        vecs[13] = mkv(mk_r(BEQ, 6, 2, 3), 0, 0, 0, 0, 0, 1, BEQ, 6, 9, 4, 16'h26, 0);
        vecs[14] = mkv(mk_r(JMP, 5, 0, 0), 0, 0, 0, 1, 5, 1, JMP, 5, 0, 0, 0, 0);
        vecs[15] = mkv(mk_r(ADD, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[16] = mkv(mk_r(ADD, 1, 2, 3), 0, 0, 0, 0, 0, 1, ADD, 1, 9, 4, 16'h26, 1);

        for (int i = 0; i < 17; i++) begin
            apply($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // JMP in the squash slot of another JMP must not redirect
        apply("jj_first", mkv(mk_r(JMP, 3, 0, 0), 0, 0, 0, 1, 3, 1, JMP, 3, 0, 0, 0, 0), 1'b0);
        apply("jj_second", mkv(mk_r(JMP, 6, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        apply("jj_after", mkv(mk_r(NOP, 0, 0, 0), 0, 0, 0, 0, 0, 1, NOP, 0, 0, 0, 0, 0), 1'b0);

        // Reset during a squash, with a JMP pending on the reset edge
        apply("mr_jmp", mkv(mk_r(JMP, 2, 0, 0), 0, 0, 0, 1, 2, 1, JMP, 2, 0, 0, 0, 0), 1'b0);
        rst = 1'b1;
        apply("mr_rst", mkv(mk_r(JMP, 7, 0, 0), 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        rst = 1'b0;
        apply("mr_squash", mkv(mk_r(NOP, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        apply("mr_r23", mkv(mk_r(ADD, 1, 2, 3), 0, 0, 0, 0, 0, 1, ADD, 1, 0, 0, 16'h26, 1),
              1'b0);
        apply("mr_r47", mkv(mk_r(ADD, 2, 4, 7), 0, 0, 0, 0, 0, 1, ADD, 2, 0, 0, 16'h4E, 1),
              1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
